// File: rtl/alu_arbiter_if.sv
// ============================================================================
//  Module   : alu_arbiter_if
//  Brief    : Requester, response and ALU-side signal bundle for alu_arbiter.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef ADD
`define ADD 3'd0
`define SUB 3'd1
`define AND 3'd2
`define OR  3'd3
`define XOR 3'd4
`define SLL 3'd5
`define SRL 3'd6
`define MUL 3'd7
`endif

interface alu_arbiter_if #(
    parameter int DSIZE = `DSIZE,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [DSIZE-1:0] req0_a;
    logic [DSIZE-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic [DSIZE-1:0] req0_imm;

    logic             req1_valid;
    logic             req1_ready;
    logic [DSIZE-1:0] req1_a;
    logic [DSIZE-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic [DSIZE-1:0] req1_imm;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [DSIZE-1:0] rsp_out;
    logic             rsp_zero;

    logic [DSIZE-1:0] alu_a;
    logic [DSIZE-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [DSIZE-1:0] alu_imm;
    logic [DSIZE-1:0] alu_out;
    logic             alu_zero;

    logic             busy;

    // Requesters and the external ALU together form the master side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_imm,
        output req1_valid, req1_a, req1_b, req1_op, req1_imm,
        output rsp0_ready, rsp1_ready,
        output alu_out, alu_zero,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_out, rsp_zero,
        input  alu_a, alu_b, alu_op, alu_imm,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_imm,
        input  req1_valid, req1_a, req1_b, req1_op, req1_imm,
        input  rsp0_ready, rsp1_ready,
        input  alu_out, alu_zero,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_out, rsp_zero,
        output alu_a, alu_b, alu_op, alu_imm,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Round-robin sharing of one external combinational ALU between
//             two requesters, with registered operands and registered result.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_arbiter #(
    parameter int DSIZE = 16,
    parameter int OPW   = 3
) (
    input  wire logic    clk,
    input  wire logic    rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_owner;
    logic             r_last_grant;
    logic [DSIZE-1:0] r_alu_a;
    logic [DSIZE-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic [DSIZE-1:0] r_alu_imm;
    logic [DSIZE-1:0] r_rsp_out;
    logic             r_rsp_zero;

    logic             w_grant;
    logic             w_idle_open;
    logic             w_req0_ready;
    logic             w_req1_ready;
    logic             w_accept;
    logic             w_owner_ready;
    logic             w_rsp_done;
    logic             w_rsp0_valid;
    logic             w_rsp1_valid;
    logic             w_busy;

    logic [DSIZE-1:0] w_sel_a;
    logic [DSIZE-1:0] w_sel_b;
    logic [OPW-1:0]   w_sel_op;
    logic [DSIZE-1:0] w_sel_imm;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester always wins; under contention the
    // requester that did not complete last goes next.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle_open  = (r_state == ST_IDLE) && !rst;
    assign w_req0_ready = w_idle_open && !w_grant && bus.req0_valid;
    assign w_req1_ready = w_idle_open &&  w_grant && bus.req1_valid;
    assign w_accept     = w_req0_ready || w_req1_ready;

    assign w_owner_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
    assign w_rsp_done    = (r_state == ST_RESP) && w_owner_ready;

    assign w_sel_a   = w_grant ? bus.req1_a   : bus.req0_a;
    assign w_sel_b   = w_grant ? bus.req1_b   : bus.req0_b;
    assign w_sel_op  = w_grant ? bus.req1_op  : bus.req0_op;
    assign w_sel_imm = w_grant ? bus.req1_imm : bus.req0_imm;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rsp0_valid = 1'b0;
        w_rsp1_valid = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_accept) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_rsp0_valid = !r_owner;
                w_rsp1_valid =  r_owner;
                if (w_owner_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy       = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, result and arbitration-history registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_alu_imm    <= '0;
            r_rsp_out    <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner   <= w_grant;
                r_alu_a   <= w_sel_a;
                r_alu_b   <= w_sel_b;
                r_alu_op  <= w_sel_op;
                r_alu_imm <= w_sel_imm;
            end
            // The ALU settles on the registered operands during EXEC.
            if (r_state == ST_EXEC) begin
                r_rsp_out  <= bus.alu_out;
                r_rsp_zero <= bus.alu_zero;
            end
            if (w_rsp_done) begin
                r_last_grant <= r_owner;
            end
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.rsp0_valid = w_rsp0_valid;
    assign bus.rsp1_valid = w_rsp1_valid;
    assign bus.rsp_out    = r_rsp_out;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_imm    = r_alu_imm;
    assign bus.busy       = w_busy;

endmodule

`default_nettype wire
